// File: rtl/amm_csr_bridge_pkg.sv
// Shared types and limits for the Avalon-MM to csr_if bridge.
// Holds the FSM state encoding and the read-latency counter sizing.
package amm_csr_bridge_pkg;

    localparam int unsigned RD_LAT_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_RESP
    } state_e;

endpackage

// File: rtl/csr_if.sv
// Word-wide CSR bus between the bridge (master) and the downstream address decoder.
interface csr_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BE_W   = 2,
    parameter int unsigned DATA_W = BE_W * 8
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   be;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output addr,
        output wr_data,
        output be,
        output wr_en,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_data,
        input  be,
        input  wr_en,
        output rd_data
    );

endinterface

// File: rtl/amm_csr_bridge.sv
// Avalon-MM slave to csr_if master bridge: single-cycle writes, fixed-latency reads
// with the host stalled through waitrequest until read data is returned.
module amm_csr_bridge
    import amm_csr_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BE_W   = 2,
    parameter int unsigned DATA_W = BE_W * 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] amm_address_i,
    input  logic              amm_write_i,
    input  logic              amm_read_i,
    input  logic [DATA_W-1:0] amm_writedata_i,
    input  logic [BE_W-1:0]   amm_byteenable_i,
    output logic              amm_waitrequest_o,
    output logic [DATA_W-1:0] amm_readdata_o,
    output logic              amm_readdatavalid_o,
    csr_if.master             csr_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        wr_en_d  = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read; the read is dropped.
                if (amm_write_i) begin
                    addr_d  = amm_address_i;
                    wdata_d = amm_writedata_i;
                    be_d    = amm_byteenable_i;
                    wr_en_d = 1'b1;
                end else if (amm_read_i) begin
                    addr_d  = amm_address_i;
                    be_d    = amm_byteenable_i;
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = csr_o.rd_data;
                    rvalid_d = 1'b1;
                    state_d  = RD_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_en_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wr_en_q  <= wr_en_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign amm_waitrequest_o   = rst_i | (state_q != IDLE);
    assign amm_readdata_o      = rdata_q;
    assign amm_readdatavalid_o = rvalid_q;

    assign csr_o.addr    = addr_q;
    assign csr_o.wr_data = wdata_q;
    assign csr_o.be      = be_q;
    assign csr_o.wr_en   = wr_en_q;

endmodule

// File: tb/tb_amm_csr_bridge.sv
// Bench for amm_csr_bridge: four instances (RD_LAT 1, 0, 15, 3) share one Avalon master and
// are compared every cycle against a transaction-level model of acceptance and response timing.
module tb_amm_csr_bridge;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned DATA_W = 16;
    localparam int          NDUT   = 4;

    function automatic int unsigned lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 0;
            2:       return 15;
            default: return 3;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;

    logic [NDUT-1:0]   waitreq;
    logic [NDUT-1:0]   rvalid;
    logic [NDUT-1:0]   wr_en_a;
    logic [DATA_W-1:0] rdata_a  [NDUT];
    logic [ADDR_W-1:0] caddr_a  [NDUT];
    logic [DATA_W-1:0] cwdata_a [NDUT];
    logic [BE_W-1:0]   cbe_a    [NDUT];

    // Contents of the register banks behind the decoder.
    logic [DATA_W-1:0] rf [1 << ADDR_W];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int proto_viol = 0;
    bit final_req  = 1'b0;
    bit final_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int unsigned LAT = lat_of(g);

        csr_if #(.ADDR_W(ADDR_W), .BE_W(BE_W), .DATA_W(DATA_W)) csr_bus ();

        // Address history so read data appears exactly LAT cycles after the address.
        logic [ADDR_W-1:0] hist [16];
        always @(posedge clk) begin
            hist[0] <= csr_bus.addr;
            for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
        end

        if (LAT == 0) begin : g_comb
            assign csr_bus.rd_data = rf[csr_bus.addr];
        end else begin : g_dly
            assign csr_bus.rd_data = rf[hist[LAT-1]];
        end

        amm_csr_bridge #(
            .ADDR_W(ADDR_W),
            .BE_W  (BE_W),
            .DATA_W(DATA_W),
            .RD_LAT(LAT)
        ) u_dut (
            .clk_i              (clk),
            .rst_i              (rst),
            .amm_address_i      (address),
            .amm_write_i        (wr),
            .amm_read_i         (rd),
            .amm_writedata_i    (wdata),
            .amm_byteenable_i   (be),
            .amm_waitrequest_o  (waitreq[g]),
            .amm_readdata_o     (rdata_a[g]),
            .amm_readdatavalid_o(rvalid[g]),
            .csr_o              (csr_bus)
        );

        assign wr_en_a[g]  = csr_bus.wr_en;
        assign caddr_a[g]  = csr_bus.addr;
        assign cwdata_a[g] = csr_bus.wr_data;
        assign cbe_a[g]    = csr_bus.be;
    end

    task automatic chk(input string tag, input int g, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[dut%0d] cycle=%0d observed=0x%0h expected=0x%0h",
                   tag, g, cyc, obs, exp);
        end
    endtask

    // Reference model: when each instance may accept, and what it must emit per cycle.
    int                free_at   [NDUT];
    int                wr_due    [NDUT];
    int                rv_due    [NDUT];
    logic [DATA_W-1:0] rv_data   [NDUT];
    logic [ADDR_W-1:0] exp_addr  [NDUT];
    logic [DATA_W-1:0] exp_wdata [NDUT];
    logic [BE_W-1:0]   exp_be    [NDUT];
    logic [DATA_W-1:0] exp_rdata [NDUT];
    bit                known     [NDUT];

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            free_at[g] = 0;
            wr_due[g]  = -1;
            rv_due[g]  = -1;
            known[g]   = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit busy;
        if (rst === 1'b0 && wr === 1'b1 && rd === 1'b1) begin
            proto_viol++;
            $display("note: protocol violation, read and write together at addr 0x%0h", address);
        end
        for (int g = 0; g < NDUT; g++) begin
            busy = rst || (cyc < free_at[g]);
            chk("waitrequest", g, 32'(waitreq[g]), 32'(busy));
            if (known[g]) begin
                chk("wr_en", g, 32'(wr_en_a[g]), 32'(wr_due[g] == cyc));
                if (wr_due[g] == cyc) chk("wr_data", g, 32'(cwdata_a[g]), 32'(exp_wdata[g]));
                chk("csr_addr", g, 32'(caddr_a[g]), 32'(exp_addr[g]));
                chk("csr_be", g, 32'(cbe_a[g]), 32'(exp_be[g]));
                chk("readdatavalid", g, 32'(rvalid[g]), 32'(rv_due[g] == cyc));
                if (rv_due[g] == cyc) exp_rdata[g] = rv_data[g];
                chk("readdata", g, 32'(rdata_a[g]), 32'(exp_rdata[g]));
            end
            if (rst) begin
                known[g]     = 1'b1;
                free_at[g]   = cyc + 1;
                wr_due[g]    = -1;
                rv_due[g]    = -1;
                exp_addr[g]  = '0;
                exp_wdata[g] = '0;
                exp_be[g]    = '0;
                exp_rdata[g] = '0;
            end else if (!busy) begin
                if (wr) begin
                    wr_due[g]    = cyc + 1;
                    exp_addr[g]  = address;
                    exp_wdata[g] = wdata;
                    exp_be[g]    = be;
                end else if (rd) begin
                    rv_due[g]   = cyc + 2 + int'(lat_of(g));
                    rv_data[g]  = rf[address];
                    free_at[g]  = cyc + 3 + int'(lat_of(g));
                    exp_addr[g] = address;
                    exp_be[g]   = be;
                end
            end
        end
        if (final_req && !final_done) begin
            chk("proto_violations", 0, 32'(proto_viol), 32'd1);
            final_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
        wr      = w;
        rd      = r;
        address = a;
        wdata   = d;
        be      = b;
        step();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        address = '0;
        wdata   = '0;
        be      = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) rf[i] = DATA_W'($urandom);
        rf[10'h020] = 16'h1234;
        repeat (3) step();
        rst = 1'b0;
        idle(2);

        // Single write, then a burst of four back-to-back writes.
        drive(1'b1, 1'b0, 10'h012, 16'hBEEF, 2'b11);
        idle(2);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom), 2'b11);
        idle(2);

        // Single read of a known value.
        drive(1'b0, 1'b1, 10'h020, 16'h0000, 2'b11);
        idle(20);

        // Read held high: every instance re-accepts as soon as it is idle again.
        rd      = 1'b1;
        address = 10'h0A5;
        be      = 2'b01;
        repeat (40) step();
        rd = 1'b0;
        idle(20);

        // Reset two cycles into a read, then a normal write.
        drive(1'b0, 1'b1, 10'h033, 16'h0000, 2'b11);
        step();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        drive(1'b1, 1'b0, 10'h044, 16'hA5A5, 2'b10);
        idle(20);

        // Read and write together: only the write takes effect.
        drive(1'b1, 1'b1, 10'h005, 16'h5A5A, 2'b11);
        idle(20);

        // Randomised traffic; requests hitting a busy instance are ignored by it.
        for (int i = 0; i < 300; i++) begin
            int op;
            op      = int'($urandom_range(0, 3));
            wr      = (op == 1);
            rd      = (op >= 2);
            address = ADDR_W'($urandom_range(0, 63));
            wdata   = DATA_W'($urandom);
            be      = BE_W'($urandom);
            step();
        end
        wr = 1'b0;
        rd = 1'b0;
        idle(20);

        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) step();
        if (!final_done) begin
            $display("FAIL final_check timeout observed=pending required=done");
            $fatal(1, "final check never ran");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
